// File: rtl/mem_port_if.sv
// Bundles the fetch, load/store and memory-side signals of the unified-memory
// arbiter. The arbiter takes the slave view; requesters and memory take master.
interface mem_port_if #(
  parameter int ADDR_W    = 8,
  parameter int WORD_SIZE = 32
);
  logic                 if_req;
  logic [ADDR_W-1:0]    if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [WORD_SIZE-1:0] if_rdata;

  logic                 dm_req;
  logic                 dm_we;
  logic [ADDR_W-1:0]    dm_addr;
  logic [WORD_SIZE-1:0] dm_wdata;
  logic                 dm_gnt;
  logic                 dm_rvalid;
  logic [WORD_SIZE-1:0] dm_rdata;

  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-way arbiter in front of the single-ported unified memory: fetch vs.
// load/store, combinational grant and memory drive, registered read responses.
module mem_port_rsp #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [WORD_SIZE-1:0] rdata_in,
  output logic                 rvalid,
  output logic [WORD_SIZE-1:0] rdata
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= capture;
      if (capture) rdata <= rdata_in;
    end
  end
endmodule

module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int WORD_SIZE  = 32,
  parameter int ARB_MODE   = 0,
  parameter int MAX_STREAK = 4
) (
  input logic       clk,
  input logic       rst,
  mem_port_if.slave bus
);
  localparam int         NUM_REQ    = 2;
  localparam int         IF_IDX     = 0;
  localparam int         DM_IDX     = 1;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

  owner_e     last_owner, owner_nxt;
  logic [3:0] streak, streak_nxt;
  logic       gnt_if, gnt_dm;

  logic [NUM_REQ-1:0]                cap;
  logic [NUM_REQ-1:0]                rvalid;
  logic [NUM_REQ-1:0][WORD_SIZE-1:0] rdata;

  // Grant: a lone requester always wins; on contention the mode decides.
  always_comb begin
    gnt_if = 1'b0;
    gnt_dm = 1'b0;
    if (!rst) begin
      if (bus.if_req && bus.dm_req) begin
        if (ARB_MODE == 0) begin
          if (streak == STREAK_MAX) gnt_if = 1'b1;
          else                      gnt_dm = 1'b1;
        end else begin
          if (last_owner == OWN_DM) gnt_if = 1'b1;
          else                      gnt_dm = 1'b1;
        end
      end else begin
        gnt_if = bus.if_req;
        gnt_dm = bus.dm_req;
      end
    end
  end

  // Streak counts data wins only while fetch is actually waiting.
  always_comb begin
    owner_nxt  = last_owner;
    streak_nxt = streak;
    if (gnt_if)      owner_nxt = OWN_IF;
    else if (gnt_dm) owner_nxt = OWN_DM;
    if (gnt_if || !bus.if_req)
      streak_nxt = '0;
    else if (gnt_dm && streak != STREAK_MAX)
      streak_nxt = streak + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_IF;
      streak     <= '0;
    end else begin
      last_owner <= owner_nxt;
      streak     <= streak_nxt;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (gnt_if) begin
      bus.mem_addr = bus.if_addr;
    end else if (gnt_dm) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_we    = bus.dm_we;
      bus.mem_wdata = bus.dm_wdata;
    end
  end

  // Stores are acknowledged by dm_gnt alone, so they never capture a response.
  assign cap[IF_IDX] = gnt_if;
  assign cap[DM_IDX] = gnt_dm & ~bus.dm_we;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_rsp
    mem_port_rsp #(.WORD_SIZE(WORD_SIZE)) u_rsp (
      .clk      (clk),
      .rst      (rst),
      .capture  (cap[r]),
      .rdata_in (bus.mem_rdata),
      .rvalid   (rvalid[r]),
      .rdata    (rdata[r])
    );
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.dm_gnt    = gnt_dm;
  assign bus.if_rvalid = rvalid[IF_IDX];
  assign bus.if_rdata  = rdata[IF_IDX];
  assign bus.dm_rvalid = rvalid[DM_IDX];
  assign bus.dm_rdata  = rdata[DM_IDX];
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single shared 256x32 unified memory between the instruction-fetch requester and the data load/store requester. Each cycle it grants at most one requester and drives the memory address, write-enable and write data combinationally. Read data is captured into per-requester response registers with a one-cycle valid strobe. It sits between the CPU fetch/MEM stages and the memory block.

Parameters:
ADDR_W, 8, memory word-address width
WORD_SIZE, 32, data word width
ARB_MODE, 0, 0 = data-priority with starvation guard; 1 = strict round-robin
MAX_STREAK, 4, consecutive data grants allowed while if_req is pending (ARB_MODE 0 only); legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  instruction fetch request; held with stable if_addr until granted
if_addr  input  ADDR_W  fetch word address
if_gnt  output  1  fetch granted this cycle (combinational)
if_rvalid  output  1  if_rdata valid; one-cycle pulse
if_rdata  output  WORD_SIZE  registered fetch data
dm_req  input  1  data request; held with stable dm_we/dm_addr/dm_wdata until granted
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data word address
dm_wdata  input  WORD_SIZE  store data
dm_gnt  output  1  data request granted this cycle (combinational)
dm_rvalid  output  1  dm_rdata valid (loads only); one-cycle pulse
dm_rdata  output  WORD_SIZE  registered load data
mem_addr  output  ADDR_W  address to memory
mem_we  output  1  memory write enable
mem_wdata  output  WORD_SIZE  memory write data
mem_rdata  input  WORD_SIZE  memory combinational read data

Behaviour:
- Reset (async, rst=1): if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0, streak=0, last_owner=IF, if_gnt=dm_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0. Grants are forced 0 while rst is high.
- State: last_owner {IF, DM} (1 bit); streak counter, 4 bits, saturating at MAX_STREAK.
- Grant decision, combinational, at most one grant per cycle:
  - Only one requester is active: it is granted.
  - Both active, ARB_MODE 0: dm granted unless streak == MAX_STREAK, in which case if is granted.
  - Both active, ARB_MODE 1: grant goes to the requester that is not last_owner.
  - Neither active: no grant.
- Memory drive:
  - Granted IF: mem_addr=if_addr, mem_we=0.
  - Granted DM: mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata.
  - No grant: mem_addr=0, mem_we=0, mem_wdata=0.
- Latency: a read granted in cycle N captures mem_rdata at the edge ending N. Its rvalid is high and its rdata valid for exactly cycle N+1. rdata holds its value afterwards until the next read for that requester.
- Stores: the write commits at the edge ending the grant cycle. No dm_rvalid is produced. dm_gnt is the store acknowledge.
- Sequential updates at each posedge:
  - last_owner is set to the granted side.
  - streak increments (saturating) on a DM grant while if_req=1, resets to 0 on any IF grant, and resets to 0 when if_req=0.
- Back-to-back: a requester may be granted every cycle; rvalid may be high on consecutive cycles.
- Ordering: a store at address A granted in cycle N, followed by a read of A in cycle N+1 or later, returns the new data.
- Ungranted requests wait. The arbiter never drops a held request. A requester that deasserts req before its grant is simply not served.
- Reset mid-operation: pending rvalid pulses are cleared and no write is issued while rst=1.

Test Plan:
- Reset: assert rst with dm_req=1, dm_we=1 -> mem_we=0, all gnt/rvalid=0, rdata=0. Deassert rst -> dm_gnt=1 and mem_we=1 in the first cycle.
- Single fetch: mem[0x10]=0xDEADBEEF, if_req with if_addr=0x10 for one cycle -> if_gnt=1 in that cycle; if_rvalid=1 and if_rdata=0xDEADBEEF in the next cycle only.
- Contention, ARB_MODE 0, MAX_STREAK=4: if_req and dm_req (loads) held continuously -> grant pattern DM,DM,DM,DM,IF repeating; no more than 4 consecutive dm_gnt.
- Round-robin, ARB_MODE 1: both requests held for 6 cycles, with last_owner=IF after reset -> grants DM,IF,DM,IF,DM,IF.
- Store then fetch: dm store 0x12345678 to 0x20 in cycle N, if_req with if_addr=0x20 in cycle N+1 -> if_rdata=0x12345678 in cycle N+2; dm_rvalid stays 0 throughout.
- Reset mid-read: assert rst in cycle N+1 of a granted load -> dm_rvalid falls to 0 immediately (async), dm_rdata=0.
